// File: rtl/rns_pkg.sv
// Constants shared across the RNS-to-binary converter, plus elaboration-time
// helpers that size the half-period (2^HP == -1 mod m) reduction stages.
package rns_pkg;

  localparam int unsigned MOD_32 = 32;
  localparam int unsigned MOD_17 = 17;
  localparam int unsigned MOD_13 = 13;
  localparam int unsigned MOD_11 = 11;
  localparam int unsigned HP_11  = 5;

  function automatic int unsigned hp_chunks(int unsigned w, int unsigned hp);
    return (w + hp - 1) / hp;
  endfunction

  // Largest value chunk k can hold; the top chunk may be narrower than hp.
  function automatic int unsigned hp_chunk_max(int unsigned w, int unsigned hp, int unsigned k);
    int unsigned rem;
    if (hp * k >= w) return 0;
    rem = w - hp * k;
    if (rem > hp) rem = hp;
    return (32'd1 << rem) - 32'd1;
  endfunction

  // Smallest multiple of m covering the worst-case sum of odd chunks.
  function automatic int unsigned hp_offset(int unsigned w, int unsigned hp, int unsigned m);
    int unsigned s;
    int unsigned off;
    s   = 0;
    off = 0;
    for (int unsigned k = 1; k < hp_chunks(w, hp); k += 2)
      s += hp_chunk_max(w, hp, k);
    while (off < s) off += m;
    return off;
  endfunction

  function automatic int unsigned hp_max_sum(int unsigned w, int unsigned hp, int unsigned m);
    int unsigned s;
    s = hp_offset(w, hp, m);
    for (int unsigned k = 0; k < hp_chunks(w, hp); k += 2)
      s += hp_chunk_max(w, hp, k);
    return s;
  endfunction

endpackage

// File: rtl/hp_fold_11.sv
// Combinational alternating chunk sum: sum(c_even) - sum(c_odd) + OFF, which is
// congruent to the input modulo MOD and never negative.
module hp_fold_11
  import rns_pkg::*;
#(
  parameter int unsigned W_IN  = 17,
  parameter int unsigned W_OUT = 7,
  parameter int unsigned HP    = HP_11,
  parameter int unsigned MOD   = MOD_11
) (
  input  logic [W_IN-1:0]  i_val,
  output logic [W_OUT-1:0] o_sum
);

  localparam int unsigned N   = hp_chunks(W_IN, HP);
  localparam int unsigned EW  = N * HP;
  localparam int unsigned OFF = hp_offset(W_IN, HP, MOD);

  logic [EW-1:0] w_ext;

  assign w_ext = EW'(i_val);

  // Even chunks are added before odd ones are subtracted, so every partial
  // sum stays within [0, max sum] and W_OUT never wraps.
  always_comb begin
    o_sum = W_OUT'(OFF);
    for (int unsigned k = 0; k < N; k += 2)
      o_sum = o_sum + W_OUT'(w_ext[k*HP +: HP]);
    for (int unsigned k = 1; k < N; k += 2)
      o_sum = o_sum - W_OUT'(w_ext[k*HP +: HP]);
  end

endmodule

// File: rtl/reduce_mod_hp_11.sv
// Registered x mod 11 with one cycle of latency: two half-period folds, then
// conditional subtraction of 22 and 11.
module reduce_mod_hp_11
  import rns_pkg::*;
#(
  parameter int unsigned IN_W  = 17,
  parameter int unsigned OUT_W = 5,
  parameter int unsigned MOD   = MOD_11,
  parameter int unsigned HP    = HP_11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_val,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_res
);

  localparam int unsigned S1_W = $clog2(hp_max_sum(IN_W, HP, MOD) + 1);
  localparam int unsigned S2_W = 6;

  logic [S1_W-1:0] w_s1;
  logic [S2_W-1:0] w_s2;
  logic [4:0]      w_c1;
  logic [3:0]      w_res;

  hp_fold_11 #(
    .W_IN  (IN_W),
    .W_OUT (S1_W),
    .HP    (HP),
    .MOD   (MOD)
  ) u_fold1 (
    .i_val (in_val),
    .o_sum (w_s1)
  );

  // Second fold maps the 7-bit sum into 8..42.
  hp_fold_11 #(
    .W_IN  (S1_W),
    .W_OUT (S2_W),
    .HP    (HP),
    .MOD   (MOD)
  ) u_fold2 (
    .i_val (w_s1),
    .o_sum (w_s2)
  );

  assign w_c1  = (w_s2 >= S2_W'(2 * MOD)) ? 5'(w_s2 - S2_W'(2 * MOD)) : w_s2[4:0];
  assign w_res = (w_c1 >= 5'(MOD)) ? 4'(w_c1 - 5'(MOD)) : w_c1[3:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_res   <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) out_res <= OUT_W'(w_res);
    end
  end

endmodule

// File: tb/tb_reduce_mod_hp_11.sv
// Directed and swept checks of reduce_mod_hp_11 against hand-computed residues.
module tb_reduce_mod_hp_11;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [16:0] in_val;
  logic        out_valid;
  logic [4:0]  out_res;

  int unsigned n_chk;
  int unsigned n_fail;
  int unsigned n_bit4;

  reduce_mod_hp_11 #(
    .IN_W  (17),
    .OUT_W (5)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_val    (in_val),
    .out_valid (out_valid),
    .out_res   (out_res)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Apply inputs, clock once, sample 1 time unit after the edge.
  task automatic step(input logic v, input int unsigned val);
    in_valid = v;
    in_val   = 17'(val);
    @(posedge clk);
    #1;
  endtask

  int unsigned dir_val [11] = '{0, 10, 11, 131071, 131065, 32, 1024, 32768, 100, 121, 54321};
  int unsigned dir_exp [11] = '{0, 10,  0,      6,      0, 10,    1,    10,   1,   0,     3};
  int unsigned str_val [3]  = '{12345, 99999, 65536};
  int unsigned str_exp [3]  = '{3, 9, 9};

  initial begin
    n_chk  = 0;
    n_fail = 0;
    n_bit4 = 0;
    reset    = 1'b1;
    in_valid = 1'b1;
    in_val   = 17'd100;

    for (int i = 0; i < 2; i++) begin
      step(1'b1, 100);
      chk("reset_valid", 32'(out_valid), 0);
      chk("reset_res", 32'(out_res), 0);
    end
    reset = 1'b0;
    step(1'b1, 100);
    chk("first_valid", 32'(out_valid), 1);
    chk("first_res", 32'(out_res), 1);

    for (int i = 0; i < 11; i++) begin
      step(1'b1, dir_val[i]);
      chk("dir_valid", 32'(out_valid), 1);
      chk($sformatf("dir_res_%0d", dir_val[i]), 32'(out_res), dir_exp[i]);
    end

    step(1'b0, 0);
    chk("idle_valid", 32'(out_valid), 0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, str_val[i]);
      chk("stream_valid", 32'(out_valid), 1);
      chk($sformatf("stream_res_%0d", i), 32'(out_res), str_exp[i]);
    end

    step(1'b1, 5);
    chk("bubble_v0", 32'(out_valid), 1);
    chk("bubble_r0", 32'(out_res), 5);
    step(1'b0, 77);
    chk("bubble_v1", 32'(out_valid), 0);
    chk("bubble_hold", 32'(out_res), 5);
    step(1'b1, 22);
    chk("bubble_v2", 32'(out_valid), 1);
    chk("bubble_r2", 32'(out_res), 0);

    step(1'b1, 7);
    chk("pre_rst_res", 32'(out_res), 7);
    reset = 1'b1;
    step(1'b1, 9);
    chk("midrst_valid", 32'(out_valid), 0);
    chk("midrst_res", 32'(out_res), 0);
    reset = 1'b0;

    // Low range exhaustively, the top range up to all-ones, then random operands.
    for (int unsigned v = 0; v < 8192; v++) begin
      step(1'b1, v);
      if (out_res[4]) n_bit4++;
      chk("sweep_lo", 32'(out_res), v % 11);
    end
    for (int unsigned v = 131072 - 4096; v < 131072; v++) begin
      step(1'b1, v);
      if (out_res[4]) n_bit4++;
      chk("sweep_hi", 32'(out_res), v % 11);
    end
    for (int i = 0; i < 4000; i++) begin
      int unsigned v;
      v = $urandom_range(131071, 0);
      step(1'b1, v);
      if (out_res[4]) n_bit4++;
      chk($sformatf("rand_%0d", v), 32'(out_res), v % 11);
    end
    chk("sweep_valid", 32'(out_valid), 1);
    chk("upper_bit_zero", n_bit4, 0);

    step(1'b0, 0);
    chk("final_idle", 32'(out_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
